// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  function automatic logic parity_calc(input logic [8:0] data, input logic odd);
    return ^data ^ odd;
  endfunction
endpackage

// File: rtl/uart_sync_edge.sv
// uart_sync_edge: 2-flop synchroniser with falling-edge detect, idles high
module uart_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic fall
);
  logic s1, prev;
  // metastability chain plus one-cycle history for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, q, prev} <= 3'b111;
    else begin
      s1   <= d;
      q    <= s1;
      prev <= q;
    end
  assign fall = prev & ~q;
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with parity/stop checks and valid/ready output
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int CYCLE_DIV  = 100,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 dout_ready,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic                 sample_strobe
);
  localparam int HALF = CYCLE_DIV / 2;
  localparam int CW   = $clog2(CYCLE_DIV);
  localparam int BW   = $clog2(DATA_BITS + 1);
  rx_state_t state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [BW-1:0] bcnt, nxt_bcnt;
  logic [DATA_BITS-1:0] sh;
  logic rxs, fall, samp, commit, perr, ferr;
  uart_sync_edge u_sync (.clk(clk), .rst(rst), .d(rx), .q(rxs), .fall(fall));
  function automatic logic sample_at(input rx_state_t s, input logic [CW-1:0] c);
    return s == START ? c == CW'(HALF) : s != IDLE && c == CW'(CYCLE_DIV - 1);
  endfunction
  assign samp = sample_at(state, cnt);
  // next-state, bit timing and commit decision
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    nxt_bcnt  = bcnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (fall) nxt_state = START;
      end
      START: if (samp) begin
        nxt_cnt   = '0;
        nxt_state = rxs ? IDLE : DATA;
      end
      DATA: if (samp) begin
        nxt_cnt  = '0;
        nxt_bcnt = bcnt == BW'(DATA_BITS - 1) ? '0 : bcnt + 1'b1;
        if (bcnt == BW'(DATA_BITS - 1)) nxt_state = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (samp) begin
        nxt_cnt   = '0;
        nxt_state = STOP;
      end
      STOP: if (samp) begin
        nxt_cnt   = '0;
        commit    = bcnt == BW'(STOP_BITS - 1);
        nxt_bcnt  = commit ? '0 : bcnt + 1'b1;
        nxt_state = commit ? IDLE : STOP;
      end
      default: nxt_state = IDLE;
    endcase
  end
  // FSM state, counters and per-frame accumulation
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bcnt          <= '0;
      sh            <= '0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      busy          <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      bcnt          <= nxt_bcnt;
      busy          <= nxt_state != IDLE;
      sample_strobe <= sample_at(nxt_state, nxt_cnt);
      if (state == IDLE) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (samp && state == DATA) sh <= {rxs, sh[DATA_BITS-1:1]};
      if (samp && state == PARITY) perr <= parity_calc(9'(sh), 1'(PARITY_ODD)) ^ rxs;
      if (samp && state == STOP && !rxs) ferr <= 1'b1;
    end
  // output handshake: load on free slot, flag overrun when the slot is still held
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit && (!dout_valid || dout_ready)) begin
      dout       <= sh;
      parity_err <= perr;
      frame_err  <= ferr | ~rxs;
      dout_valid <= 1'b1;
      if (dout_valid) overrun <= 1'b0;
    end else if (commit) overrun <= 1'b1;
    else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed scoreboard bench for 8N1 and 8E1 receivers
module tb_uart_rx_frame;
  typedef struct {logic [7:0] d; logic p; logic f;} exp_t;
  logic clk = 0, rst = 1, ready = 1, rx0 = 1, rx1 = 1;
  logic [7:0] d0, d1;
  logic v0, pe0, fe0, ov0, b0, st0, v1, pe1, fe1, ov1, b1, st1, vp0 = 0;
  int pass_n = 0, total_n = 0, cyc = 0, vcnt0 = 0, vrise = 0;
  int stq[$];
  exp_t q0[$], q1[$];
  uart_rx_frame #(.DATA_BITS(8), .CYCLE_DIV(16)) u0 (
    .clk(clk), .rst(rst), .rx(rx0), .dout_ready(ready), .dout(d0), .dout_valid(v0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0), .sample_strobe(st0));
  uart_rx_frame #(.DATA_BITS(8), .CYCLE_DIV(16), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .dout_ready(ready), .dout(d1), .dout_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1), .sample_strobe(st1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total_n++;
    assert (o === e) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask
  task automatic drive_bit(input int u, input logic v);
    if (u == 0) rx0 = v; else rx1 = v;
    repeat (16) @(negedge clk);
  endtask
  task automatic send(input int u, input logic [7:0] d, input logic stop, input int par);
    drive_bit(u, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(u, d[i]);
    if (par >= 0) drive_bit(u, 1'(par));
    drive_bit(u, stop);
    drive_bit(u, 1'b1);
  endtask
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (st0) stq.push_back(cyc);
    if (v0 && !vp0) vrise <= cyc;
    if (v0) vcnt0 <= vcnt0 + 1;
    vp0 <= v0;
  end
  always @(negedge clk) begin
    exp_t e;
    if (v0 && ready) begin
      if (q0.size() == 0) chk("unexpected0", 32'(d0), 32'hffff_ffff);
      else begin
        e = q0.pop_front();
        chk("dout0", 32'(d0), 32'(e.d));
        chk("perr0", 32'(pe0), 32'(e.p));
        chk("ferr0", 32'(fe0), 32'(e.f));
      end
    end
    if (v1 && ready) begin
      if (q1.size() == 0) chk("unexpected1", 32'(d1), 32'hffff_ffff);
      else begin
        e = q1.pop_front();
        chk("dout1", 32'(d1), 32'(e.d));
        chk("perr1", 32'(pe1), 32'(e.p));
        chk("ferr1", 32'(fe1), 32'(e.f));
      end
    end
  end
  initial begin
    int sb, vb, bad;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(d0), 0);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_flags", 32'({pe0, fe0, ov0}), 0);
    chk("rst_busy", 32'(b0), 0);
    chk("rst_strobe", 32'(st0), 0);
    rst = 0;
    repeat (5) @(negedge clk);
    sb = stq.size();
    vb = vcnt0;
    q0.push_back('{8'hA5, 1'b0, 1'b0});
    send(0, 8'hA5, 1'b1, -1);
    chk("a5_strobes", 32'(stq.size() - sb), 10);
    bad = 0;
    for (int i = sb + 1; i < stq.size(); i++) if (stq[i] - stq[i-1] != 16) bad++;
    chk("a5_spacing", 32'(bad), 0);
    chk("a5_valid_len", 32'(vcnt0 - vb), 1);
    chk("a5_valid_rise", 32'(vrise), 32'(stq[$] + 1));
    chk("a5_sb_empty", 32'(q0.size()), 0);
    sb = stq.size();
    vb = vcnt0;
    rx0 = 0;
    repeat (4) @(negedge clk);
    rx0 = 1;
    repeat (40) @(negedge clk);
    chk("glitch_strobes", 32'(stq.size() - sb), 1);
    chk("glitch_novalid", 32'(vcnt0 - vb), 0);
    chk("glitch_busy", 32'(b0), 0);
    q0.push_back('{8'h3C, 1'b0, 1'b1});
    send(0, 8'h3C, 1'b0, -1);
    q0.push_back('{8'h3D, 1'b0, 1'b0});
    send(0, 8'h3D, 1'b1, -1);
    chk("ferr_sb_empty", 32'(q0.size()), 0);
    q1.push_back('{8'h07, 1'b1, 1'b0});
    send(1, 8'h07, 1'b1, 0);
    q1.push_back('{8'h07, 1'b0, 1'b0});
    send(1, 8'h07, 1'b1, 1);
    chk("par_sb_empty", 32'(q1.size()), 0);
    ready = 0;
    q0.push_back('{8'h11, 1'b0, 1'b0});
    send(0, 8'h11, 1'b1, -1);
    send(0, 8'h22, 1'b1, -1);
    chk("ovr_dout", 32'(d0), 32'h11);
    chk("ovr_valid", 32'(v0), 1);
    chk("ovr_flag", 32'(ov0), 1);
    @(posedge clk);
    #1 ready = 1;
    @(posedge clk);
    #1 ready = 0;
    chk("ovr_valid_clr", 32'(v0), 0);
    chk("ovr_flag_clr", 32'(ov0), 0);
    chk("ovr_dout_hold", 32'(d0), 32'h11);
    chk("ovr_sb_empty", 32'(q0.size()), 0);
    @(negedge clk) ready = 1;
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    chk("mid_busy", 32'(b0), 1);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("arst_dout", 32'(d0), 0);
    chk("arst_valid", 32'(v0), 0);
    chk("arst_busy", 32'(b0), 0);
    chk("arst_flags", 32'({pe0, fe0, ov0, st0}), 0);
    rx0 = 1;
    repeat (4) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(b0), 0);
    q0.push_back('{8'h5A, 1'b0, 1'b0});
    send(0, 8'h5A, 1'b1, -1);
    chk("post_rst_sb_empty", 32'(q0.size()), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive framer; the successor to the fixed-width bit-stream sampling register. Oversamples the asynchronous `rx` line, detects and qualifies the start bit, and samples each data, optional parity and stop bit at its midpoint. Checks parity and stop bits, then presents the assembled word on a valid/ready handshake with error flags. Sits between the board pin and any consumer of received bytes.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `CYCLE_DIV`, 100: `clk` cycles per bit, ≥4; `HALF = CYCLE_DIV/2` (integer division).
- `PARITY_EN`, 0: 1 means a parity bit follows the data.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN=0`.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rx`  in  1  serial line, idle high, LSB first; asynchronous to `clk`.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `dout`  out  DATA_BITS  received word; reset 0.
- `dout_valid`  out  1  `dout` and error flags valid; reset 0.
- `parity_err`  out  1  parity mismatch on the presented frame; reset 0.
- `frame_err`  out  1  a stop bit was sampled 0 on the presented frame; reset 0.
- `overrun`  out  1  sticky: a completed frame was dropped; reset 0.
- `busy`  out  1  FSM not in IDLE; reset 0.
- `sample_strobe`  out  1  one-cycle pulse on every bit-sample cycle (debug); reset 0.

## Operation
- `rx` passes through a 2-flop synchroniser. A falling edge is detected on the synchronised signal: the current sample is 0 and the previous sample was 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a falling edge, go to START and clear `cnt` to 0.
- START: when `cnt==HALF`, sample. If the sample is 0, clear `cnt` and go to DATA. If it is 1, the start was false: return to IDLE with no output.
- DATA: sample when `cnt==CYCLE_DIV-1`, then clear `cnt`. Each sample shifts into the MSB of the shift register, shifting right. After `DATA_BITS` samples, go to PARITY if `PARITY_EN`, otherwise to STOP.
- PARITY: one sample. The error is the XOR of the data bits and the parity bit, XORed with `PARITY_ODD`; 1 means error.
- STOP: `STOP_BITS` samples. Any 0 sets the frame's frame error.
- Commit happens on the cycle of the last stop-bit sample, at the bit midpoint. The FSM goes to IDLE immediately, so back-to-back frames are accepted.
- A frame is committed even when it has errors.
- Commit when `dout_valid=0`, or when `dout_valid=1 && dout_ready=1` in the same cycle:
  - `dout`, `parity_err` and `frame_err` are loaded.
  - `dout_valid` is 1 next cycle.
  - The frame is not counted as an overrun.
- Commit when `dout_valid=1 && dout_ready=0`:
  - The new frame is discarded and `dout` is held.
  - `overrun` is set to 1.
- Handshake: `dout_valid && dout_ready` with no simultaneous commit drops `dout_valid` next cycle and clears `overrun`. `dout` holds its value after acceptance.
- `cnt` width is `$clog2(CYCLE_DIV)`. The bit counter width is `$clog2(DATA_BITS+1)`.
- `rst` asserted in any state asynchronously clears the FSM to IDLE and clears every output, the counters and the synchroniser (to 1, the idle level). The partially received frame is lost.

## Timing
- Synchroniser latency is 2 cycles from an `rx` transition to the edge detector.
- START is entered on the cycle after edge detection.
- The first `sample_strobe` occurs `HALF` cycles later. Subsequent strobes are exactly `CYCLE_DIV` cycles apart.
- `dout_valid` rises 1 cycle after the final stop-bit strobe.
- The frame delivers `1+DATA_BITS+PARITY_EN+STOP_BITS` strobes in total.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - `typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}`.
  - Function `parity_calc(data, odd)`, reused by the transmitter.
- Sub-module `uart_sync_edge`: 2-flop synchroniser plus falling-edge detect, with async reset to 1. Ports: `clk`, `rst`, `d`, `q`, `fall`.
- All other logic lives in `uart_rx_frame`.

## Test plan
All scenarios use `CYCLE_DIV=16`, `DATA_BITS=8` and `dout_ready=1` unless stated.
- 8N1, send 0xA5 → `dout=0xA5`, `dout_valid` high for 1 cycle, no error flags, exactly 10 strobes spaced 16 cycles apart.
- Drive a 4-cycle low glitch on idle `rx` → one strobe in START, FSM returns to IDLE, `dout_valid` never rises.
- Send 0x3C with stop bit 0 → `dout=0x3C`, `frame_err=1`. A following clean frame 0x3D gives `frame_err=0`.
- `PARITY_EN=1`, even parity, send 0x07 with parity bit 0 → `parity_err=1`. Resend with parity bit 1 → `parity_err=0`.
- `dout_ready=0`, send 0x11 then 0x22 → `dout=0x11`, `overrun=1`. Pulse `dout_ready` for one cycle → `dout_valid=0` and `overrun=0` next cycle.
- Assert `rst` mid-DATA of 0x99 → all outputs 0 immediately, `busy=0`. After release, frame 0x5A is received correctly.
